// File: rtl/conv_window_scan_ctrl.sv
// -----------------------------------------------------------------------------
// conv_window_scan_ctrl
//
// Window-scan controller for the multiply-adder tree. It sweeps (x, y, channel)
// window origins over a feature map with a fixed stride and carries a valid
// bit and a frame-last bit alongside the datapath. This lets the tree output
// be qualified D = RDY_SHIFT_REG_SIZE cycles after each coordinate is issued.
//
// Ports
//   clock        rising-edge clock for all state
//   reset        synchronous, active-high; clears everything
//   start        one-cycle strobe, honoured only while idle
//   stall        freezes the counters and the ready pipeline for the cycle
//   abort        synchronous; same clearing effect as reset, no done pulse
//   x_coord      current x origin   (X_COORD_BITWIDTH+1 bits)
//   y_coord      current y origin   (Y_COORD_BITWIDTH+1 bits)
//   ch_coord     current channel    (CH_BITWIDTH+1 bits)
//   coord_valid  coordinate is issued to the datapath this cycle
//   busy         controller is scanning or draining
//   pixel_rdy    valid data at the tree output
//   pixel_last   qualifies the pixel_rdy of the final pixel of the frame
//   done         one-cycle pulse once the final pixel has left the tree
//
// STRIDE and RDY_SHIFT_REG_SIZE must both be at least 1.
// -----------------------------------------------------------------------------
module conv_window_scan_ctrl #(
  parameter int X_COORD_BITWIDTH   = 7,
  parameter int Y_COORD_BITWIDTH   = 7,
  parameter int CH_BITWIDTH        = 3,
  parameter int X_COORD_MAX        = 27,
  parameter int Y_COORD_MAX        = 27,
  parameter int CH_MAX             = 0,
  parameter int STRIDE             = 1,
  parameter int RDY_SHIFT_REG_SIZE = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stall,
  input  logic                      abort,
  output logic [X_COORD_BITWIDTH:0] x_coord,
  output logic [Y_COORD_BITWIDTH:0] y_coord,
  output logic [CH_BITWIDTH:0]      ch_coord,
  output logic                      coord_valid,
  output logic                      busy,
  output logic                      pixel_rdy,
  output logic                      pixel_last,
  output logic                      done
);

  localparam int XW = X_COORD_BITWIDTH + 1;
  localparam int YW = Y_COORD_BITWIDTH + 1;
  localparam int CW = CH_BITWIDTH + 1;
  localparam int D  = RDY_SHIFT_REG_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN
  } state_t;

  state_t state;

  // Bit 0 is the first pipeline stage, bit D-1 lines up with the tree output.
  logic [D-1:0] v_pipe;
  logic [D-1:0] last_pipe;

  // One extra bit so origin + STRIDE can never wrap past the limit.
  logic [XW:0]   x_sum;
  logic [YW:0]   y_sum;
  logic          x_wrap;
  logic          y_wrap;
  logic          ch_wrap;
  logic          final_issue;
  logic [XW-1:0] x_next;
  logic [YW-1:0] y_next;
  logic [CW-1:0] ch_next;

  assign coord_valid = (state == ST_SCAN) & ~stall;
  assign busy        = (state != ST_IDLE);
  assign pixel_rdy   = v_pipe[D-1] & ~stall;
  assign pixel_last  = last_pipe[D-1] & ~stall;

  // Next-origin arithmetic: x innermost, then y, then channel outermost.
  // When every level wraps, all counters land on 0, which is also the value
  // they must hold in DRAIN and IDLE.
  always_comb begin
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    x_sum   = {1'b0, x_coord} + (XW+1)'(STRIDE);
    y_sum   = {1'b0, y_coord} + (YW+1)'(STRIDE);
    x_wrap  = (x_sum > (XW+1)'(X_COORD_MAX));
    y_wrap  = (y_sum > (YW+1)'(Y_COORD_MAX));
    ch_wrap = (ch_coord >= CW'(CH_MAX));
    x_next  = x_wrap ? '0 : x_sum[XW-1:0];
    y_next  = y_coord;
    ch_next = ch_coord;
    if (x_wrap) begin
      y_next = y_wrap ? '0 : y_sum[YW-1:0];
      if (y_wrap) begin
        ch_next = ch_wrap ? '0 : ch_coord + CW'(1);
      end
    end
    final_issue = coord_valid & x_wrap & y_wrap & ch_wrap;
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset || abort) begin
      // NOTE: the pipelines carry control (valid/last), not data, so they are
      // cleared with everything else; stale bits would fake a pixel_rdy.
      state     <= ST_IDLE;
      x_coord   <= '0;
      y_coord   <= '0;
      ch_coord  <= '0;
      v_pipe    <= '0;
      last_pipe <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      if (!stall) begin
        v_pipe    <= D'({v_pipe, coord_valid});
        last_pipe <= D'({last_pipe, final_issue});
      end

      case (state)
        ST_IDLE: begin
          if (start) state <= ST_SCAN;
        end

        ST_SCAN: begin
          if (!stall) begin
            x_coord  <= x_next;
            y_coord  <= y_next;
            ch_coord <= ch_next;
            if (final_issue) state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          // Nothing is issued after the final coordinate, so once the
          // last-flagged pixel leaves on a non-stalled cycle the pipe is empty.
          if (!stall && last_pipe[D-1]) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
